// File: rtl/vga_frame_reader.sv
// VGA timing generator that scans a windowed RGB332 image from RAM port B and
// drives 24-bit RGB with syncs, blank and frame_start kept aligned to the pixel data.
module vga_frame_reader #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned IMG_W    = 256,
  parameter int unsigned IMG_H    = 256,
  parameter int unsigned X0       = 192,
  parameter int unsigned Y0       = 112,
  parameter int unsigned RD_LAT   = 1,
  parameter logic [7:0]  BORDER   = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] pix_addr,
  input  logic [7:0]  pix_data,
  output logic        vga_hs_n,
  output logic        vga_vs_n,
  output logic        vga_blank_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start,
  output logic        vblank
);

  localparam int unsigned CW      = 10;
  localparam int unsigned AW      = 16;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] X_LO     = CW'(X0);
  localparam logic [CW-1:0] X_HI     = CW'(X0 + IMG_W);
  localparam logic [CW-1:0] Y_LO     = CW'(Y0);
  localparam logic [CW-1:0] Y_HI     = CW'(Y0 + IMG_H);

  // Bit positions of the control word travelling alongside the RAM read
  localparam int unsigned P_HS  = 0;
  localparam int unsigned P_VS  = 1;
  localparam int unsigned P_ACT = 2;
  localparam int unsigned P_WIN = 3;
  localparam int unsigned P_FS  = 4;
  localparam int unsigned PW    = 5;

  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [RD_LAT-1:0][PW-1:0] pipe_q, pipe_d;
  logic [PW-1:0] raw, tail;
  logic [7:0]    pix;
  logic [CW-1:0] x_off, y_off;
  logic          in_win;

  logic       hs_n_q, hs_n_d, vs_n_q, vs_n_d, blank_n_q, blank_n_d;
  logic       fs_q, fs_d, vblank_q, vblank_d;
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;

  // Raster position: line counter steps on each horizontal wrap
  always_comb begin
    hcnt_d = hcnt_q + CW'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CW'(1);
    end
  end

  assign in_win   = (hcnt_q >= X_LO) && (hcnt_q < X_HI) && (vcnt_q >= Y_LO) && (vcnt_q < Y_HI);
  assign x_off    = hcnt_q - X_LO;
  assign y_off    = vcnt_q - Y_LO;
  assign pix_addr = in_win ? AW'(AW'(y_off) * AW'(IMG_W) + AW'(x_off)) : '0;

  always_comb begin
    raw        = '0;
    raw[P_HS]  = (hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST);
    raw[P_VS]  = (vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST);
    raw[P_ACT] = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    raw[P_WIN] = in_win && enable;
    raw[P_FS]  = (hcnt_q == '0) && (vcnt_q == '0);
    pipe_d     = pipe_q;
    pipe_d[0]  = raw;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Output stage: the pipeline tail lines up with the pixel the RAM returns now
  always_comb begin
    tail      = pipe_q[RD_LAT-1];
    pix       = tail[P_WIN] ? pix_data : BORDER;
    hs_n_d    = ~tail[P_HS];
    vs_n_d    = ~tail[P_VS];
    blank_n_d = tail[P_ACT];
    fs_d      = tail[P_FS];
    r_d       = '0;
    g_d       = '0;
    b_d       = '0;
    if (tail[P_ACT]) begin
      r_d = {pix[7:5], pix[7:5], pix[7:6]};
      g_d = {pix[4:2], pix[4:2], pix[4:3]};
      b_d = {4{pix[1:0]}};
    end
    vblank_d = (vcnt_d >= V_ACT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      pipe_q    <= '0;
      hs_n_q    <= 1'b1;
      vs_n_q    <= 1'b1;
      blank_n_q <= 1'b0;
      fs_q      <= 1'b0;
      vblank_q  <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      pipe_q    <= pipe_d;
      hs_n_q    <= hs_n_d;
      vs_n_q    <= vs_n_d;
      blank_n_q <= blank_n_d;
      fs_q      <= fs_d;
      vblank_q  <= vblank_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end

  assign vga_hs_n    = hs_n_q;
  assign vga_vs_n    = vs_n_q;
  assign vga_blank_n = blank_n_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign frame_start = fs_q;
  assign vblank      = vblank_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader on a scaled-down raster (56x32, 16x8 window)
// with a two-cycle RAM; every cycle is also compared against a position-based model.
module tb_vga_frame_reader;

  localparam int HA = 40, HF = 4, HS = 6, HB = 6, HT = HA + HF + HS + HB;
  localparam int VA = 24, VF = 2, VS = 3, VB = 3, VT = VA + VF + VS + VB;
  localparam int IW = 16, IH = 8, XO = 12, YO = 6;
  localparam int LAT = 2, L = LAT + 1;
  localparam int FRAME = HT * VT;
  localparam logic [7:0] BRD = 8'h1F;

  logic        clk, reset, enable;
  logic [15:0] pix_addr;
  logic [7:0]  pix_data;
  logic        vga_hs_n, vga_vs_n, vga_blank_n, frame_start, vblank;
  logic [7:0]  vga_r, vga_g, vga_b;

  vga_frame_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .IMG_W(IW), .IMG_H(IH), .X0(XO), .Y0(YO),
    .RD_LAT(LAT), .BORDER(BRD)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pix_addr(pix_addr), .pix_data(pix_data),
    .vga_hs_n(vga_hs_n), .vga_vs_n(vga_vs_n), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start), .vblank(vblank)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Two-cycle synchronous RAM, mem[a] = a ^ 8'hE0
  logic [7:0] mem [256];
  logic [7:0] q1, q2;
  always @(posedge clk) begin
    q1 <= mem[pix_addr[7:0]];
    q2 <= q1;
  end
  assign pix_data = q2;

  int   errors = 0, checks = 0;
  int   n = 0, run = 0;
  int   hs_low = 0, vs_low = 0, fs_cnt = 0, vb_cnt = 0;
  logic en_hist [8192];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at n=%0d: observed %h, expected %h", tag, n, obs, exp);
    end
  endtask

  function automatic logic [23:0] rgb332(input logic [7:0] p);
    return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], {4{p[1:0]}}};
  endfunction

  // Expected {frame_start, hs_n, vs_n, blank_n, r, g, b} for cycle k after release
  function automatic logic [27:0] exp_out(input int k);
    int m, x, y;
    logic act, win, hs, vs;
    logic [7:0] p;
    if (k < L) return {1'b0, 1'b1, 1'b1, 1'b0, 24'h0};
    m   = k - L;
    x   = m % HT;
    y   = (m / HT) % VT;
    act = (x < HA) && (y < VA);
    win = (x >= XO) && (x < XO + IW) && (y >= YO) && (y < YO + IH);
    hs  = (x >= HA + HF) && (x < HA + HF + HS);
    vs  = (y >= VA + VF) && (y < VA + VF + VS);
    p   = (win && en_hist[m]) ? mem[8'((y - YO) * IW + (x - XO))] : BRD;
    return {(x == 0 && y == 0), !hs, !vs, act, act ? rgb332(p) : 24'h0};
  endfunction

  function automatic logic [15:0] exp_addr(input int k);
    int x, y;
    x = k % HT;
    y = (k / HT) % VT;
    if ((x >= XO) && (x < XO + IW) && (y >= YO) && (y < YO + IH))
      return 16'((y - YO) * IW + (x - XO));
    return 16'h0;
  endfunction

  task automatic cycle_check();
    logic [27:0] obs;
    obs = {frame_start, vga_hs_n, vga_vs_n, vga_blank_n, vga_r, vga_g, vga_b};
    chk("out", 32'(obs), 32'(exp_out(n)));
    chk("addr", 32'(pix_addr), 32'(exp_addr(n)));
    chk("vblank", 32'(vblank), 32'(((n / HT) % VT) >= VA));
    if (run == 0) begin
      if (n >= L && n < L + FRAME) begin
        if (!vga_hs_n) hs_low++;
        if (!vga_vs_n) vs_low++;
        if (frame_start) fs_cnt++;
      end
      if (n < FRAME && vblank) vb_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run_to(input int t);
    while (n < t) begin
      cycle_check();
      en_hist[n] = enable;
      tick();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, 32'({vga_hs_n, vga_vs_n, vga_blank_n, frame_start, vblank}), 32'b11000);
    chk(tag, 32'({vga_r, vga_g, vga_b}), 32'h0);
    chk(tag, 32'(pix_addr), 32'h0);
  endtask

  initial begin
    if (XO + IW > HA || YO + IH > VA) begin
      $display("FAIL param: image window exceeds active area");
      $fatal(1);
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hE0;
    reset  = 1'b0;
    enable = 1'b1;

    // Held in reset for five cycles
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst_hold");
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst_end");
    reset = 1'b1;
    n = 0;

    run_to(2);    chk("blank_pre", 32'(vga_blank_n), 32'h0);
    run_to(3);    chk("blank_at_L", 32'(vga_blank_n), 32'h1);
                  chk("fs_first", 32'(frame_start), 32'h1);
                  chk("rgb_border00", 32'({vga_r, vga_g, vga_b}), 32'h00FFFF);
    run_to(4);    chk("fs_pulse", 32'(frame_start), 32'h0);
    run_to(46);   chk("hs_before", 32'(vga_hs_n), 32'h1);
    run_to(47);   chk("hs_start", 32'(vga_hs_n), 32'h0);
    run_to(52);   chk("hs_last", 32'(vga_hs_n), 32'h0);
    run_to(53);   chk("hs_end", 32'(vga_hs_n), 32'h1);
    run_to(348);  chk("addr_first", 32'(pix_addr), 32'h0000);
    run_to(349);  chk("addr_second", 32'(pix_addr), 32'h0001);
    run_to(351);  chk("rgb_first", 32'({vga_r, vga_g, vga_b}), 32'hFF0000);
    run_to(755);  chk("addr_last", 32'(pix_addr), 32'h007F);
    run_to(756);  chk("addr_past", 32'(pix_addr), 32'h0000);
    run_to(758);  chk("rgb_last", 32'({vga_r, vga_g, vga_b}), 32'h92FFFF);
    run_to(759);  chk("rgb_past", 32'({vga_r, vga_g, vga_b}), 32'h00FFFF);
    run_to(1343); chk("vblank_pre", 32'(vblank), 32'h0);
    run_to(1344); chk("vblank_rise", 32'(vblank), 32'h1);
    run_to(1795); chk("fs_period", 32'(frame_start), 32'h1);
                  chk("hs_low_frame", 32'(hs_low), 32'd192);
                  chk("vs_low_frame", 32'(vs_low), 32'd168);
                  chk("fs_per_frame", 32'(fs_cnt), 32'd1);
                  chk("vblank_frame", 32'(vb_cnt), 32'd448);

    // Enable dropped for four pixels inside row 2 of the image
    run_to(2256); enable = 1'b0;
    run_to(2258); chk("rgb_en_before", 32'({vga_r, vga_g, vga_b}), 32'hDB00FF);
    run_to(2259); chk("rgb_en_off", 32'({vga_r, vga_g, vga_b}), 32'h00FFFF);
    run_to(2260); enable = 1'b1;
    run_to(2263); chk("rgb_en_back", 32'({vga_r, vga_g, vga_b}), 32'hDB4900);

    // Reset asserted mid-frame at position (30,10)
    run_to(4174);
    chk("blank_pre_rst", 32'(vga_blank_n), 32'h1);
    reset = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst_mid_hold");
    reset = 1'b1;
    n = 0;
    run = 1;
    run_to(2);    chk("no_stale_rgb", 32'({vga_r, vga_g, vga_b, vga_blank_n}), 32'h0);
    run_to(3);    chk("fs_after_rst", 32'(frame_start), 32'h1);
    run_to(600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Display-side reader for the pixel frame buffer. The CPU pipeline writes 8-bit pixels into port A of the dual-port pixel RAM. This block drives port B: it generates 640x480@60 VGA timing from the 25 MHz pixel clock and scans a 256x256 image window out of the RAM. It expands each RGB332 pixel to 24-bit RGB and registers all VGA outputs with pipeline-aligned syncs. It replaces the free-running pixel address counter on the display clock domain.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, in pixels
- H_SYNC, 96: hsync pulse width, in pixels
- H_BP, 48: horizontal back porch, in pixels
- V_ACTIVE, 480: visible lines
- V_FP, 10: vertical front porch, in lines
- V_SYNC, 2: vsync width, in lines
- V_BP, 33: vertical back porch, in lines
- IMG_W, 256: image width; must be a power of 2
- IMG_H, 256: image height
- X0, 192: image left column
- Y0, 112: image top line
- RD_LAT, 1: RAM port-B read latency in cycles; legal values are 1 or 2
- BORDER, 8'h00: RGB332 colour shown outside the image window

Ports:
- clk, input, 1: pixel clock (25 MHz)
- reset, input, 1: asynchronous, active-low reset
- enable, input, 1: 1 = show the image; 0 = show BORDER everywhere in the active area
- pix_addr, output, 16: RAM port-B read address
- pix_data, input, 8: RAM port-B q, valid RD_LAT cycles after pix_addr
- vga_hs_n, output, 1: horizontal sync, active low
- vga_vs_n, output, 1: vertical sync, active low
- vga_blank_n, output, 1: 1 during the visible area
- vga_r, output, 8: red channel
- vga_g, output, 8: green channel
- vga_b, output, 8: blue channel
- frame_start, output, 1: one-cycle pulse marking the first visible pixel (0,0) of each frame
- vblank, output, 1: 1 while vcnt >= V_ACTIVE (CPU-side frame sync)

## Operation
- **Horizontal counter (hcnt)**, 10 bits, runs 0..H_TOTAL-1, where H_TOTAL = 800.
  - Visible: 0..639.
  - Front porch: 640..655.
  - Sync: 656..751.
  - Back porch: 752..799.
- **Vertical counter (vcnt)**, 10 bits, runs 0..524.
  - Increments when hcnt wraps from 799 to 0.
  - vcnt wraps to 0 when hcnt wraps at vcnt = 524.
  - Regions: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- **Window test:** in_win = (X0 <= hcnt < X0+IMG_W) AND (Y0 <= vcnt < Y0+IMG_H).
- **Address:**
  - Inside the window: pix_addr = {(vcnt-Y0)[7:0], (hcnt-X0)[7:0]}, i.e. row-major, and equal to (vcnt-Y0)*256 + (hcnt-X0).
  - Outside the window: pix_addr = 0.
  - pix_addr is driven combinationally from the counter registers, so it is stable for the whole cycle.
- **Delay pipeline:** a RD_LAT-deep shift register carries {hs, vs, active, in_win & enable, frame_start_raw} alongside the RAM read.
  - Raw signals: hs = (656 <= hcnt <= 751), vs = (490 <= vcnt <= 491), active = (hcnt < 640 AND vcnt < 480).
- **Output register** (one stage after the pipeline):
  - If active_d = 0: RGB = 0 and vga_blank_n = 0.
  - Else, if win_d = 1: pixel p = pix_data. Otherwise p = BORDER.
  - RGB332 expansion: vga_r = {p[7:5], p[7:5], p[7:6]}, vga_g = {p[4:2], p[4:2], p[4:3]}, vga_b = {p[1:0] replicated 4 times}.
- **enable:** sampled every cycle. A change takes effect from the next pixel and does not disturb timing.
- **vblank:** registered, and not delayed through the pipeline.

## Timing
- **Reset:** while reset = 0 (asynchronous), all of the following hold:
  - hcnt = 0, vcnt = 0, pipeline cleared.
  - vga_hs_n = 1, vga_vs_n = 1, vga_blank_n = 0.
  - RGB = 0, frame_start = 0, vblank = 0.
  - pix_addr = 0, because hcnt = vcnt = 0 lies outside the default window.
- **After reset release:** the first rising edge advances hcnt to 1. Counters start at (0,0) on release.
- **Latency:** every VGA output lags the counter position by exactly L = RD_LAT+1 cycles. This applies to syncs, blank, RGB and frame_start, so they all stay mutually aligned.
- **Pixel pairing:** pix_data is sampled RD_LAT cycles after pix_addr is presented. The RAM must not stall.
- **frame_start:** high for one cycle, L cycles after (hcnt, vcnt) = (0, 0).
- **Wrap:** the transition (799, 524) -> (0, 0) happens in one cycle with no extra idle cycle. The frame period is exactly 420000 cycles.
- **Reset mid-frame:** outputs go to their reset values immediately. The pipeline is flushed, so no stale pixel is emitted after release.
- **Parameter constraint:** X0+IMG_W <= H_ACTIVE and Y0+IMG_H <= V_ACTIVE. The bench checks this with an elaboration assertion.

## Test plan
- **Reset values:** hold reset low for 5 cycles, then release. Expect all outputs at their reset values during reset; hcnt = 1 one cycle after release; vga_blank_n = 1 at cycle L.
- **First image pixel:** RAM model returns pix_data = 8'hE0 at address 0. When (hcnt, vcnt) = (192, 112), pix_addr = 16'h0000. L cycles later, vga_r = 8'hFF, vga_g = 8'h00, vga_b = 8'h00.
- **Last image pixel:** at (447, 367), pix_addr = 16'hFFFF. At (448, 367), pix_addr = 0; with BORDER = 8'h1F, vga_r = 8'h00, vga_g = 8'hFF, vga_b = 8'hFF.
- **Sync timing:** vga_hs_n is low for exactly 96 cycles per line, starting L cycles after hcnt = 656. vga_vs_n is low for exactly 1600 cycles per frame. frame_start recurs every 420000 cycles, and vblank is high for 36000 cycles per frame.
- **Enable toggle:** drop enable to 0 mid-line while inside the window. From the pixel issued after the drop, output shows BORDER; hs/vs periods are unchanged. Raise enable again and image pixels resume.
- **Reset mid-frame:** assert reset at (300, 200) for 3 cycles. Outputs reset immediately. After release, the first frame_start occurs L cycles after release, and no RGB value from before the reset appears.
